// File: rtl/controler_if.sv
// Control bus between the series-evaluation controller and its datapath.
// The controller sits on the slave modport (it receives start and the datapath
// flags and drives the strobes); the datapath or a bench uses the master modport.
interface controler_if;
    logic start;
    logic parity;
    logic stop_sign;
    logic ready;
    logic cnt_en;
    logic cnt_init0;
    logic sel_rom;
    logic sel_x;
    logic reg_x_ld;
    logic reg_y_ld;
    logic reg_tmp_ld;
    logic invert;
    logic minus;
    logic reg_res_ld;
    logic reg_tmp_init1;
    logic reg_res_init1;

    modport slave (
        input  start,
        input  parity,
        input  stop_sign,
        output ready,
        output cnt_en,
        output cnt_init0,
        output sel_rom,
        output sel_x,
        output reg_x_ld,
        output reg_y_ld,
        output reg_tmp_ld,
        output invert,
        output minus,
        output reg_res_ld,
        output reg_tmp_init1,
        output reg_res_init1
    );

    modport master (
        output start,
        output parity,
        output stop_sign,
        input  ready,
        input  cnt_en,
        input  cnt_init0,
        input  sel_rom,
        input  sel_x,
        input  reg_x_ld,
        input  reg_y_ld,
        input  reg_tmp_ld,
        input  invert,
        input  minus,
        input  reg_res_ld,
        input  reg_tmp_init1,
        input  reg_res_init1
    );
endinterface

// File: rtl/controler.sv
// Control FSM for the iterative series-evaluation unit (y = sum +/- rom[k]*x^k).
// Produces only control strobes; arithmetic lives in the datapath.
// Optional macro CONTROLER_START_WAIT_EN adds SWAIT between IDLE and INIT so that
// a held start launches only one run, after start is released.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready, waiting for start
// SWAIT | start seen, waiting for start to drop (macro build only)
// INIT  | load x, clear term counter, tmp=1, res=1
// MULX  | tmp <= tmp * x
// MULR  | tmp <= tmp * rom[cnt]
// ACC   | res <= res +/- tmp, advance counter, exit when stop_sign
// WRY   | y <= +/- res
module controler (
    input  logic        clk,
    input  logic        rst,
    controler_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_MULX  = 3'd2,
        S_MULR  = 3'd3,
        S_ACC   = 3'd4,
        S_WRY   = 3'd5
`ifdef CONTROLER_START_WAIT_EN
        ,S_SWAIT = 3'd6
`endif
    } state_t;

    // acc/wry qualify the parity-dependent (Mealy) outputs minus/invert
    typedef struct packed {
        logic ready;
        logic cnt_en;
        logic cnt_init0;
        logic sel_rom;
        logic sel_x;
        logic reg_x_ld;
        logic reg_y_ld;
        logic reg_tmp_ld;
        logic reg_res_ld;
        logic reg_tmp_init1;
        logic reg_res_init1;
        logic acc;
        logic wry;
    } ctl_t;

    state_t state;
    ctl_t   ctl_q;

    function automatic state_t next_of(input state_t s, input logic start, input logic stop_sign);
        state_t n;
        n = S_IDLE;
        case (s)
            S_IDLE: begin
                if (start) begin
`ifdef CONTROLER_START_WAIT_EN
                    n = S_SWAIT;
`else
                    n = S_INIT;
`endif
                end else begin
                    n = S_IDLE;
                end
            end
`ifdef CONTROLER_START_WAIT_EN
            S_SWAIT: n = start ? S_SWAIT : S_INIT;
`endif
            S_INIT:  n = S_MULX;
            S_MULX:  n = S_MULR;
            S_MULR:  n = S_ACC;
            S_ACC:   n = stop_sign ? S_WRY : S_MULX;
            S_WRY:   n = S_IDLE;
            default: n = S_IDLE;
        endcase
        return n;
    endfunction

    function automatic ctl_t decode(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_IDLE: c.ready = 1'b1;
            S_INIT: begin
                c.reg_x_ld      = 1'b1;
                c.cnt_init0     = 1'b1;
                c.reg_tmp_init1 = 1'b1;
                c.reg_res_init1 = 1'b1;
            end
            S_MULX: begin
                c.sel_x      = 1'b1;
                c.reg_tmp_ld = 1'b1;
            end
            S_MULR: begin
                c.sel_rom    = 1'b1;
                c.reg_tmp_ld = 1'b1;
            end
            S_ACC: begin
                c.reg_res_ld = 1'b1;
                c.cnt_en     = 1'b1;
                c.acc        = 1'b1;
            end
            S_WRY: begin
                c.reg_y_ld = 1'b1;
                c.wry      = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // State register; strobes are registered from the next state so they equal
    // a decode of the current state without a combinational decode tree on the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            ctl_q <= decode(S_IDLE);
        end else begin
            state <= next_of(state, bus.start, bus.stop_sign);
            ctl_q <= decode(next_of(state, bus.start, bus.stop_sign));
        end
    end

    // Output drive; minus/invert follow parity within the same cycle.
    always_comb begin
        bus.ready         = ctl_q.ready;
        bus.cnt_en        = ctl_q.cnt_en;
        bus.cnt_init0     = ctl_q.cnt_init0;
        bus.sel_rom       = ctl_q.sel_rom;
        bus.sel_x         = ctl_q.sel_x;
        bus.reg_x_ld      = ctl_q.reg_x_ld;
        bus.reg_y_ld      = ctl_q.reg_y_ld;
        bus.reg_tmp_ld    = ctl_q.reg_tmp_ld;
        bus.reg_res_ld    = ctl_q.reg_res_ld;
        bus.reg_tmp_init1 = ctl_q.reg_tmp_init1;
        bus.reg_res_init1 = ctl_q.reg_res_init1;
        bus.minus         = ctl_q.acc & bus.parity;
        bus.invert        = ctl_q.wry & bus.parity;
    end

endmodule

// File: tb/tb_controler.sv
// Directed bench for controler: every cycle drives inputs on the falling edge,
// then compares the 13 outputs against a hand-written per-state vector.
module tb_controler;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    controler_if bus ();

    controler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ready,cnt_en,cnt_init0,sel_rom,sel_x,reg_x_ld,reg_y_ld,reg_tmp_ld,
    //  invert,minus,reg_res_ld,reg_tmp_init1,reg_res_init1}
    localparam logic [12:0] V_IDLE  = 13'b1_0000_0000_0000;
    localparam logic [12:0] V_INIT  = 13'b0_0100_1000_0011;
    localparam logic [12:0] V_MULX  = 13'b0_0001_0010_0000;
    localparam logic [12:0] V_MULR  = 13'b0_0010_0010_0000;
    localparam logic [12:0] V_ACC0  = 13'b0_1000_0000_0100;
    localparam logic [12:0] V_ACC1  = 13'b0_1000_0000_1100;
    localparam logic [12:0] V_WRY0  = 13'b0_0000_0100_0000;
    localparam logic [12:0] V_WRY1  = 13'b0_0000_0101_0000;
    localparam logic [12:0] V_SWAIT = 13'b0_0000_0000_0000;

    logic [12:0] outv;
    assign outv = {bus.ready, bus.cnt_en, bus.cnt_init0, bus.sel_rom, bus.sel_x,
                   bus.reg_x_ld, bus.reg_y_ld, bus.reg_tmp_ld, bus.invert, bus.minus,
                   bus.reg_res_ld, bus.reg_tmp_init1, bus.reg_res_init1};

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, let outputs settle, compare.
    task automatic cyc(input logic r, input logic s, input logic p, input logic st,
                       input string tag, input logic [12:0] exp);
        @(negedge clk);
        rst           = r;
        bus.start     = s;
        bus.parity    = p;
        bus.stop_sign = st;
        #1;
        check(tag, outv, exp);
    endtask

    // IDLE cycle that samples start, plus the wait state in the macro build.
    task automatic launch(input string tag);
        cyc(0, 1, 0, 0, {tag, "_idle"}, V_IDLE);
`ifdef CONTROLER_START_WAIT_EN
        cyc(0, 0, 0, 0, {tag, "_swait"}, V_SWAIT);
`endif
    endtask

    initial begin
        n_total       = 0;
        n_bad         = 0;
        rst           = 1'b1;
        bus.start     = 1'b1;
        bus.parity    = 1'b1;
        bus.stop_sign = 1'b1;
        @(posedge clk);
        @(posedge clk);

        // reset state, then start=0 keeps IDLE
        cyc(0, 0, 0, 0, "rst_idle", V_IDLE);
        cyc(0, 0, 0, 0, "hold_idle", V_IDLE);

        // single-term run
        launch("t2");
        cyc(0, 0, 0, 0, "t2_init", V_INIT);
        cyc(0, 0, 0, 0, "t2_mulx", V_MULX);
        cyc(0, 0, 0, 0, "t2_mulr", V_MULR);
        cyc(0, 0, 0, 1, "t2_acc",  V_ACC0);
        cyc(0, 0, 0, 0, "t2_wry",  V_WRY0);
        cyc(0, 0, 0, 0, "t2_idle", V_IDLE);

        // three terms, parity 0,1,0; parity/stop_sign outside ACC must not matter
        launch("t3");
        cyc(0, 0, 1, 1, "t3_init",  V_INIT);
        cyc(0, 0, 1, 1, "t3_mulx1", V_MULX);
        cyc(0, 0, 1, 1, "t3_mulr1", V_MULR);
        cyc(0, 0, 0, 0, "t3_acc1",  V_ACC0);
        cyc(0, 0, 1, 1, "t3_mulx2", V_MULX);
        cyc(0, 0, 0, 1, "t3_mulr2", V_MULR);
        cyc(0, 0, 1, 0, "t3_acc2",  V_ACC1);
        cyc(0, 0, 0, 0, "t3_mulx3", V_MULX);
        cyc(0, 0, 0, 0, "t3_mulr3", V_MULR);
        cyc(0, 0, 0, 1, "t3_acc3",  V_ACC0);
        cyc(0, 0, 0, 0, "t3_wry",   V_WRY0);
        cyc(0, 0, 1, 1, "t3_idle",  V_IDLE);

        // reset during MULR aborts without a reg_y_ld pulse
        launch("t4");
        cyc(0, 0, 0, 0, "t4_init", V_INIT);
        cyc(0, 0, 0, 0, "t4_mulx", V_MULX);
        cyc(1, 0, 0, 1, "t4_mulr", V_MULR);
        cyc(0, 0, 0, 0, "t4_idle", V_IDLE);
        cyc(0, 0, 0, 0, "t4_idle2", V_IDLE);

        // start toggling mid-loop is ignored; WRY with parity=1 inverts
        launch("t5");
        cyc(0, 1, 0, 0, "t5_init",  V_INIT);
        cyc(0, 1, 0, 0, "t5_mulx1", V_MULX);
        cyc(0, 0, 0, 0, "t5_mulr1", V_MULR);
        cyc(0, 1, 0, 0, "t5_acc1",  V_ACC0);
        cyc(0, 0, 0, 0, "t5_mulx2", V_MULX);
        cyc(0, 1, 0, 0, "t5_mulr2", V_MULR);
        cyc(0, 1, 1, 1, "t5_acc2",  V_ACC1);
        cyc(0, 1, 1, 0, "t5_wry",   V_WRY1);
        cyc(0, 0, 0, 0, "t5_idle",  V_IDLE);

`ifdef CONTROLER_START_WAIT_EN
        // held start parks in SWAIT until released
        cyc(0, 1, 0, 0, "t6_idle",   V_IDLE);
        cyc(0, 1, 0, 0, "t6_swait1", V_SWAIT);
        cyc(0, 1, 0, 0, "t6_swait2", V_SWAIT);
        cyc(0, 1, 0, 0, "t6_swait3", V_SWAIT);
        cyc(0, 0, 0, 0, "t6_swait4", V_SWAIT);
        cyc(0, 0, 0, 0, "t6_init",   V_INIT);
        cyc(0, 0, 0, 0, "t6_mulx",   V_MULX);
`else
        // held start relaunches back to back
        cyc(0, 1, 0, 0, "t6_idle",  V_IDLE);
        cyc(0, 1, 0, 0, "t6_init",  V_INIT);
        cyc(0, 1, 0, 0, "t6_mulx",  V_MULX);
        cyc(0, 1, 0, 0, "t6_mulr",  V_MULR);
        cyc(0, 1, 0, 1, "t6_acc",   V_ACC0);
        cyc(0, 1, 0, 0, "t6_wry",   V_WRY0);
        cyc(0, 1, 0, 0, "t6_idle2", V_IDLE);
        cyc(0, 0, 0, 0, "t6_init2", V_INIT);
        cyc(0, 0, 0, 0, "t6_mulx2", V_MULX);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
